// File: rtl/if_fetch_q.sv
// Fetch queue between the PC register and the ID stage.
// Accepted pcs reserve a slot in program order. Aligned pcs issue an imem read.
// Misaligned pcs become exception entries. Responses fill slots in order, and
// ID pops filled entries from the head. A flush empties the queue and counts the
// reads still in flight so their responses are discarded when they return.
module if_fetch_q #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              pc_invalid_i,
    input  logic              hold_i,
    input  logic              flush,
    input  logic              stall_id,
    output logic              stallreq_if_o,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_exc
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Repeated flushes can stack discarded reads beyond DEPTH, so drop gets headroom.
    localparam int DROP_W = PTR_W + 4;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    // Slot storage
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  exc_q;
    logic [DEPTH-1:0]  filled_q;

    // Pointers and counters
    logic [PTR_W-1:0]  alloc_q, alloc_d;
    logic [PTR_W-1:0]  fill_q,  fill_d;
    logic [PTR_W-1:0]  rd_q,    rd_d;
    logic [CNT_W-1:0]  used_q,  used_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [DROP_W-1:0] drop_q,  drop_d;

    logic slot_free;
    logic fetch_ok;
    logic acc_aligned;
    logic acc_exc;
    logic accept;
    logic resp_drop;
    logic resp_fill;
    logic pop;

    // Accept / response / pop decisions; request outputs are forced low while in reset
    always_comb begin
        slot_free     = (used_q < CNT_W'(DEPTH));
        fetch_ok      = ~rst & ce_i & ~hold_i & ~flush & slot_free;
        imem_req      = fetch_ok & ~pc_invalid_i;
        imem_addr     = pc_i;
        acc_aligned   = imem_req & imem_gnt;
        // An exception entry waits until every earlier read has returned so it stays in order.
        acc_exc       = fetch_ok & pc_invalid_i & (outst_q == '0) & (drop_q == '0);
        accept        = acc_aligned | acc_exc;
        stallreq_if_o = ~rst & ce_i & ~hold_i & ~accept;
        resp_drop     = imem_rvalid & (drop_q != '0);
        // A response with nothing outstanding and nothing to drop is stray and ignored.
        resp_fill     = imem_rvalid & (drop_q == '0) & (outst_q != '0);
        id_valid      = (used_q != '0) & filled_q[rd_q];
        id_pc         = pc_q[rd_q];
        id_inst       = inst_q[rd_q];
        id_exc        = exc_q[rd_q];
        pop           = id_valid & ~stall_id & ~flush;
    end

    // Next-state for pointers and counters
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        alloc_d = alloc_q;
        fill_d  = fill_q;
        rd_d    = rd_q;
        used_d  = used_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        if (flush) begin
            alloc_d = '0;
            fill_d  = '0;
            rd_d    = '0;
            used_d  = '0;
            outst_d = '0;
            // Everything still in flight, minus a response consumed this cycle, is discarded later.
            drop_d  = drop_q + DROP_W'(outst_q) - DROP_W'(resp_drop) - DROP_W'(resp_fill);
        end else begin
            alloc_d = alloc_q + PTR_W'(accept);
            // Exception entries are born filled, so fill steps over them when allocated.
            fill_d  = fill_q + PTR_W'(resp_fill | acc_exc);
            rd_d    = rd_q + PTR_W'(pop);
            used_d  = used_q + CNT_W'(accept) - CNT_W'(pop);
            outst_d = outst_q + CNT_W'(acc_aligned) - CNT_W'(resp_fill);
            drop_d  = drop_q - DROP_W'(resp_drop);
        end
    end

    // Pointer and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            alloc_q <= '0;
            fill_q  <= '0;
            rd_q    <= '0;
            used_q  <= '0;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            rd_q    <= rd_d;
            used_q  <= used_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    // Slot writes: allocation on accept, instruction on response, clear on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the small slot array is reset so the id_* head outputs read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            exc_q    <= '0;
            filled_q <= '0;
        end else if (flush) begin
            filled_q <= '0;
        end else begin
            if (acc_aligned) begin
                pc_q[alloc_q]     <= pc_i;
                exc_q[alloc_q]    <= 1'b0;
                filled_q[alloc_q] <= 1'b0;
            end
            if (acc_exc) begin
                pc_q[alloc_q]     <= pc_i;
                inst_q[alloc_q]   <= ZERO_WORD;
                exc_q[alloc_q]    <= 1'b1;
                filled_q[alloc_q] <= 1'b1;
            end
            if (resp_fill) begin
                inst_q[fill_q]   <= imem_rdata;
                filled_q[fill_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_q.sv
// Directed testbench for if_fetch_q. The bench plays the PC register and imem.
// Inputs are driven just after each falling edge and outputs are sampled 1 ns later.
module tb_if_fetch_q;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        pc_invalid_i;
    logic        hold_i;
    logic        flush;
    logic        stall_id;
    logic        stallreq_if_o;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_exc;

    int checks = 0;
    int fails  = 0;

    if_fetch_q #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .pc_invalid_i (pc_invalid_i),
        .hold_i       (hold_i),
        .flush        (flush),
        .stall_id     (stall_id),
        .stallreq_if_o(stallreq_if_o),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_exc       (id_exc)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ce_i = 0; pc_invalid_i = 0; hold_i = 0; flush = 0; stall_id = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    endtask

    task automatic test_reset();
        cyc(); ce_i = 1; pc_i = 32'h10; imem_gnt = 1; #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin fails++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
        checks++; if (id_inst !== 32'h0) begin fails++; $display("FAIL rst_id_inst got=%h exp=0", id_inst); end
        checks++; if (id_exc !== 1'b0) begin fails++; $display("FAIL rst_id_exc got=%b exp=0", id_exc); end
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
        checks++; if (stallreq_if_o !== 1'b0) begin fails++; $display("FAIL rst_stallreq got=%b exp=0", stallreq_if_o); end
        cyc(); rst = 0; idle_inputs();
    endtask

    // Three sequential fetches, response one cycle after grant, pops on consecutive cycles
    task automatic test_basic();
        cyc(); ce_i = 1; pc_i = 32'h0; imem_gnt = 1; #1;
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL t1_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL t1_addr got=%h exp=0", imem_addr); end
        checks++; if (stallreq_if_o !== 1'b0) begin fails++; $display("FAIL t1_stallreq got=%b exp=0", stallreq_if_o); end
        cyc(); pc_i = 32'h4; imem_rvalid = 1; imem_rdata = 32'hAAAA0000; #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t1_early_valid got=%b exp=0", id_valid); end
        cyc(); pc_i = 32'h8; imem_rdata = 32'hAAAA0004; #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin fails++; $display("FAIL t1_head0 valid=%b pc=%h exp 1/0", id_valid, id_pc); end
        checks++; if (id_inst !== 32'hAAAA0000) begin fails++; $display("FAIL t1_inst0 got=%h exp=AAAA0000", id_inst); end
        cyc(); ce_i = 0; imem_gnt = 0; imem_rdata = 32'hAAAA0008; #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4) begin fails++; $display("FAIL t1_head1 valid=%b pc=%h exp 1/4", id_valid, id_pc); end
        checks++; if (id_inst !== 32'hAAAA0004) begin fails++; $display("FAIL t1_inst1 got=%h exp=AAAA0004", id_inst); end
        cyc(); imem_rvalid = 0; #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin fails++; $display("FAIL t1_head2 valid=%b pc=%h exp 1/8", id_valid, id_pc); end
        checks++; if (id_inst !== 32'hAAAA0008 || id_exc !== 1'b0) begin fails++; $display("FAIL t1_inst2 got=%h exc=%b exp=AAAA0008/0", id_inst, id_exc); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t1_empty got=%b exp=0", id_valid); end
        idle_inputs();
    endtask

    // Fill the queue while ID stalls, then release and drain in order
    task automatic test_full_stall();
        logic [31:0] pcs [5];
        pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h48; pcs[3] = 32'h4C; pcs[4] = 32'h50;
        for (int i = 0; i < 5; i++) begin
            cyc(); stall_id = 1; ce_i = 1; imem_gnt = 1; pc_i = pcs[i];
            imem_rvalid = (i > 0); imem_rdata = {16'hBBBB, pcs[(i > 0) ? i - 1 : 0][15:0]}; #1;
            if (i < 4) begin
                checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL t2_req_fill%0d got=%b exp=1", i, imem_req); end
            end
        end
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL t2_full_req got=%b exp=0", imem_req); end
        checks++; if (stallreq_if_o !== 1'b1) begin fails++; $display("FAIL t2_full_stallreq got=%b exp=1", stallreq_if_o); end
        cyc(); stall_id = 0; imem_rvalid = 0; #1;
        checks++; if (imem_req !== 1'b0 || id_pc !== 32'h40) begin fails++; $display("FAIL t2_release req=%b pc=%h exp 0/40", imem_req, id_pc); end
        cyc(); #1;
        checks++; if (imem_req !== 1'b1 || stallreq_if_o !== 1'b0) begin fails++; $display("FAIL t2_resume req=%b stallreq=%b exp 1/0", imem_req, stallreq_if_o); end
        checks++; if (id_pc !== 32'h44 || id_inst !== 32'hBBBB0044) begin fails++; $display("FAIL t2_pop1 pc=%h inst=%h exp 44/BBBB0044", id_pc, id_inst); end
        cyc(); ce_i = 0; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hBBBB0050; #1;
        checks++; if (id_pc !== 32'h48 || id_inst !== 32'hBBBB0048) begin fails++; $display("FAIL t2_pop2 pc=%h inst=%h exp 48/BBBB0048", id_pc, id_inst); end
        cyc(); imem_rvalid = 0; #1;
        checks++; if (id_pc !== 32'h4C || id_inst !== 32'hBBBB004C) begin fails++; $display("FAIL t2_pop3 pc=%h inst=%h exp 4C/BBBB004C", id_pc, id_inst); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h50 || id_inst !== 32'hBBBB0050) begin fails++; $display("FAIL t2_pop4 valid=%b pc=%h inst=%h exp 1/50/BBBB0050", id_valid, id_pc, id_inst); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t2_empty got=%b exp=0", id_valid); end
        idle_inputs();
    endtask

    // Misaligned pc waits for two outstanding reads, then enters as an exception entry
    task automatic test_misaligned();
        cyc(); ce_i = 1; imem_gnt = 1; pc_i = 32'h60;
        cyc(); pc_i = 32'h64;
        cyc(); imem_gnt = 0; pc_i = 32'h6; pc_invalid_i = 1; #1;
        checks++; if (stallreq_if_o !== 1'b1 || imem_req !== 1'b0) begin fails++; $display("FAIL t3_wait2 stallreq=%b req=%b exp 1/0", stallreq_if_o, imem_req); end
        cyc(); imem_rvalid = 1; imem_rdata = 32'hCCCC0060; #1;
        checks++; if (stallreq_if_o !== 1'b1) begin fails++; $display("FAIL t3_wait2b stallreq=%b exp 1", stallreq_if_o); end
        cyc(); imem_rdata = 32'hCCCC0064; #1;
        checks++; if (stallreq_if_o !== 1'b1) begin fails++; $display("FAIL t3_wait1 stallreq=%b exp 1", stallreq_if_o); end
        checks++; if (id_pc !== 32'h60 || id_inst !== 32'hCCCC0060) begin fails++; $display("FAIL t3_head60 pc=%h inst=%h exp 60/CCCC0060", id_pc, id_inst); end
        cyc(); imem_rvalid = 0; #1;
        checks++; if (stallreq_if_o !== 1'b0 || imem_req !== 1'b0) begin fails++; $display("FAIL t3_exc_accept stallreq=%b req=%b exp 0/0", stallreq_if_o, imem_req); end
        checks++; if (id_pc !== 32'h64) begin fails++; $display("FAIL t3_head64 pc=%h exp 64", id_pc); end
        cyc(); ce_i = 0; pc_invalid_i = 0; #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h6 || id_exc !== 1'b1 || id_inst !== 32'h0) begin fails++; $display("FAIL t3_exc_entry valid=%b pc=%h exc=%b inst=%h exp 1/6/1/0", id_valid, id_pc, id_exc, id_inst); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t3_empty got=%b exp=0", id_valid); end
        idle_inputs();
    endtask

    // Flush with three reads in flight; their responses must be discarded
    task automatic test_flush();
        cyc(); ce_i = 1; imem_gnt = 1; pc_i = 32'h80;
        cyc(); pc_i = 32'h84;
        cyc(); pc_i = 32'h88;
        cyc(); flush = 1; pc_i = 32'h100; #1;
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL t4_flush_req got=%b exp=0", imem_req); end
        cyc(); flush = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD0080; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL t4_refetch req=%b addr=%h exp 1/100", imem_req, imem_addr); end
        cyc(); ce_i = 0; imem_gnt = 0; imem_rdata = 32'hDEAD0084; #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t4_drop1 valid=%b exp=0", id_valid); end
        cyc(); imem_rdata = 32'hDEAD0088; #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t4_drop2 valid=%b exp=0", id_valid); end
        cyc(); imem_rdata = 32'hEEEE0100; #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t4_drop3 valid=%b exp=0", id_valid); end
        cyc(); imem_rvalid = 0; #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'hEEEE0100) begin fails++; $display("FAIL t4_first valid=%b pc=%h inst=%h exp 1/100/EEEE0100", id_valid, id_pc, id_inst); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t4_empty got=%b exp=0", id_valid); end
        idle_inputs();
    endtask

    // Grant withheld for five cycles: pc held, single entry results
    task automatic test_gnt_low();
        for (int i = 0; i < 5; i++) begin
            cyc(); ce_i = 1; pc_i = 32'hA0; imem_gnt = 0; #1;
            checks++; if (stallreq_if_o !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'hA0) begin fails++; $display("FAIL t5_hold%0d stallreq=%b req=%b addr=%h exp 1/1/A0", i, stallreq_if_o, imem_req, imem_addr); end
        end
        cyc(); imem_gnt = 1; #1;
        checks++; if (stallreq_if_o !== 1'b0) begin fails++; $display("FAIL t5_grant stallreq=%b exp 0", stallreq_if_o); end
        cyc(); ce_i = 0; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hF00000A0;
        cyc(); imem_rvalid = 0; #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hA0 || id_inst !== 32'hF00000A0) begin fails++; $display("FAIL t5_entry valid=%b pc=%h inst=%h exp 1/A0/F00000A0", id_valid, id_pc, id_inst); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t5_single got=%b exp=0", id_valid); end
        idle_inputs();
    endtask

    // Reset with reads in flight; stray responses afterwards must not create entries
    task automatic test_reset_mid();
        cyc(); ce_i = 1; imem_gnt = 1; pc_i = 32'hC0;
        cyc(); pc_i = 32'hC4;
        cyc(); rst = 1; pc_i = 32'hC8; #1;
        checks++; if (imem_req !== 1'b0 || stallreq_if_o !== 1'b0 || id_valid !== 1'b0) begin fails++; $display("FAIL t6_in_rst req=%b stallreq=%b valid=%b exp 0/0/0", imem_req, stallreq_if_o, id_valid); end
        cyc(); rst = 0; idle_inputs(); imem_rvalid = 1; imem_rdata = 32'h5757C0C0;
        cyc(); imem_rdata = 32'h5757C4C4; #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t6_stray1 valid=%b exp=0", id_valid); end
        cyc(); imem_rvalid = 0; #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t6_stray2 valid=%b exp=0", id_valid); end
        cyc(); ce_i = 1; imem_gnt = 1; pc_i = 32'h20; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin fails++; $display("FAIL t6_req req=%b addr=%h exp 1/20", imem_req, imem_addr); end
        cyc(); ce_i = 0; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h12340020;
        cyc(); imem_rvalid = 0; #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_inst !== 32'h12340020 || id_exc !== 1'b0) begin fails++; $display("FAIL t6_fetch valid=%b pc=%h inst=%h exc=%b exp 1/20/12340020/0", id_valid, id_pc, id_inst, id_exc); end
        cyc(); #1;
        checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL t6_empty got=%b exp=0", id_valid); end
        idle_inputs();
    endtask

    initial begin
        rst = 1; pc_i = '0; idle_inputs();
        test_reset();
        test_basic();
        test_full_stall();
        test_misaligned();
        test_flush();
        test_gnt_low();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
